vectored_int_ctrl: RTL and testbench

Parametrised vectored interrupt controller for the multicycle processor, generalising the fixed four-input priority interrupt block to N channels. It adds the following:
- per-channel edge/level sensing;
- per-channel pending latches;
- an in-service register with nested preemption;
- a req/ack/EOI handshake with the controller FSM.

It sits between device/condition-code interrupt sources and the controller sequencer, and supplies the ISR address to the PC input mux.

---
 rtl/vectored_int_ctrl.sv | 140 ++++++++++++++
 tb/tb_vectored_int_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/vectored_int_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : vectored_int_ctrl
// Brief    : N-channel vectored interrupt controller with edge/level sensing,
//            pending latches, nested in-service tracking and a req/ack/EOI
//            handshake towards the controller sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module vectored_int_ctrl #(
    parameter int unsigned           NUM_INTS   = 4,
    parameter int unsigned           PC_WIDTH   = 8,
    parameter logic [PC_WIDTH-1:0]   VEC_BASE   = 8'hF0,
    parameter int unsigned           VEC_STRIDE = 4,
    localparam int unsigned          ID_W       = (NUM_INTS > 1) ? $clog2(NUM_INTS) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_INTS-1:0] ints,
    input  logic [NUM_INTS-1:0] mask_in,
    input  logic                ld_mask,
    input  logic [NUM_INTS-1:0] mode_in,
    input  logic                ld_mode,
    input  logic                int_disable,
    input  logic                int_ack,
    input  logic                eoi,
    output logic                int_pending,
    output logic [ID_W-1:0]     int_id,
    output logic [PC_WIDTH-1:0] isr_addr,
    output logic [NUM_INTS-1:0] pend_out,
    output logic [NUM_INTS-1:0] in_service
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_REQ  = 1'b1
    } state_t;

    state_t              r_state;
    logic [NUM_INTS-1:0] r_mask;
    logic [NUM_INTS-1:0] r_mode;
    logic [NUM_INTS-1:0] r_pend;
    logic [NUM_INTS-1:0] r_in_service;
    logic [NUM_INTS-1:0] r_ints_q;
    logic [ID_W-1:0]     r_id_q;

    logic [NUM_INTS-1:0] w_rise;
    logic [NUM_INTS-1:0] w_allowed;
    logic [NUM_INTS-1:0] w_eligible;
    logic [ID_W-1:0]     w_winner;
    logic [NUM_INTS-1:0] w_eoi_clr;
    logic [NUM_INTS-1:0] w_ack_set;
    logic                w_ack;

    assign w_rise     = ints & ~r_ints_q;
    // An ack only counts while a request is actually outstanding.
    assign w_ack      = int_ack && (r_state == S_REQ);
    assign w_ack_set  = w_ack ? (NUM_INTS'(1) << r_id_q) : '0;
    // Isolate the lowest set in-service bit (highest priority ISR running).
    assign w_eoi_clr  = eoi ? (r_in_service & (~r_in_service + NUM_INTS'(1))) : '0;
    assign w_eligible = r_pend & r_mask & w_allowed;

    // A channel may preempt only if no channel at its own or a higher priority is in service.
    always_comb begin
        logic l_seen;
        l_seen    = 1'b0;
        w_allowed = '0;
        for (int i = 0; i < int'(NUM_INTS); i++) begin
            l_seen       = l_seen | r_in_service[i];
            w_allowed[i] = ~l_seen;
        end
    end

    // Priority encoder: lowest eligible index wins (scan overwrites downwards).
    always_comb begin
        w_winner = '0;
        for (int i = int'(NUM_INTS) - 1; i >= 0; i--) begin
            if (w_eligible[i]) begin
                w_winner = ID_W'(i);
            end
        end
    end

    // Config, pending, in-service and handshake state machine.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_mask       <= '0;
            r_mode       <= '0;
            r_pend       <= '0;
            r_in_service <= '0;
            r_ints_q     <= '0;
            r_id_q       <= '0;
        end else begin
            r_ints_q <= ints;
            if (ld_mask) r_mask <= mask_in;
            if (ld_mode) r_mode <= mode_in;

            // Edge channels latch until acked (a new edge beats the clear);
            // level channels simply follow the source.
            for (int i = 0; i < int'(NUM_INTS); i++) begin
                if (r_mode[i]) begin
                    if (w_rise[i]) begin
                        r_pend[i] <= 1'b1;
                    end else if (w_ack && (r_id_q == ID_W'(i))) begin
                        r_pend[i] <= 1'b0;
                    end
                end else begin
                    r_pend[i] <= ints[i];
                end
            end

            // EOI retires the pre-ack top ISR; the ack then adds id_q.
            r_in_service <= (r_in_service & ~w_eoi_clr) | w_ack_set;

            case (r_state)
                S_IDLE: begin
                    if ((w_eligible != '0) && !int_disable) begin
                        r_state <= S_REQ;
                        r_id_q  <= w_winner;
                    end
                end
                S_REQ: begin
                    // id_q stays frozen until the request is acked or withdrawn.
                    if (w_ack || int_disable) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign int_pending = (r_state == S_REQ);
    assign int_id      = r_id_q;
    assign isr_addr    = VEC_BASE + PC_WIDTH'(32'(r_id_q) * VEC_STRIDE);
    assign pend_out    = r_pend;
    assign in_service  = r_in_service;

endmodule
`default_nettype wire

// File: tb/tb_vectored_int_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_vectored_int_ctrl
// Brief    : Directed self-checking bench for vectored_int_ctrl; expected
//            requests are queued when stimulus is driven and checked when the
//            controller raises int_pending.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vectored_int_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] ints;
    logic [3:0] mask_in;
    logic       ld_mask;
    logic [3:0] mode_in;
    logic       ld_mode;
    logic       int_disable;
    logic       int_ack;
    logic       eoi;
    logic       int_pending;
    logic [1:0] int_id;
    logic [7:0] isr_addr;
    logic [3:0] pend_out;
    logic [3:0] in_service;

    typedef struct {
        logic [1:0] id;
        logic [7:0] addr;
        int         lat;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    vectored_int_ctrl #(
        .NUM_INTS   (4),
        .PC_WIDTH   (8),
        .VEC_BASE   (8'hF0),
        .VEC_STRIDE (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .ints        (ints),
        .mask_in     (mask_in),
        .ld_mask     (ld_mask),
        .mode_in     (mode_in),
        .ld_mode     (ld_mode),
        .int_disable (int_disable),
        .int_ack     (int_ack),
        .eoi         (eoi),
        .int_pending (int_pending),
        .int_id      (int_id),
        .isr_addr    (isr_addr),
        .pend_out    (pend_out),
        .in_service  (in_service)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [1:0] id, input logic [7:0] addr, input int lat);
        exp_t e;
        e.id   = id;
        e.addr = addr;
        e.lat  = lat;
        sb.push_back(e);
    endtask

    // Clock until int_pending rises (bounded), releasing single-cycle pulses
    // after the first edge, then compare against the oldest queued expectation.
    task automatic wait_req(input string tag, input logic [3:0] ints_after);
        exp_t e;
        int   cnt;
        cnt = 0;
        while (cnt < 10) begin
            tick();
            if (cnt == 0) begin
                ints    = ints_after;
                eoi     = 1'b0;
                int_ack = 1'b0;
            end
            cnt++;
            if (int_pending) break;
        end
        chk({tag, "_req_seen"}, 32'(int_pending), 32'd1);
        if (sb.size() == 0) begin
            chk({tag, "_sb_nonempty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk({tag, "_latency"}, cnt, e.lat);
            chk({tag, "_int_id"}, 32'(int_id), 32'(e.id));
            chk({tag, "_isr_addr"}, 32'(isr_addr), 32'(e.addr));
        end
    endtask

    task automatic do_ack(input logic [3:0] ints_now);
        int_ack = 1'b1;
        ints    = ints_now;
        tick();
        int_ack = 1'b0;
    endtask

    task automatic do_eoi();
        eoi = 1'b1;
        tick();
        eoi = 1'b0;
    endtask

    initial begin
        reset = 1'b0; ints = '0; mask_in = '0; ld_mask = 1'b0; mode_in = '0;
        ld_mode = 1'b0; int_disable = 1'b0; int_ack = 1'b0; eoi = 1'b0;
        tick(); tick();
        chk("rst_pending", 32'(int_pending), 32'd0);
        chk("rst_id", 32'(int_id), 32'd0);
        chk("rst_addr", 32'(isr_addr), 32'hF0);
        chk("rst_pend", 32'(pend_out), 32'd0);
        chk("rst_insvc", 32'(in_service), 32'd0);

        // Release reset, enable all channels in edge mode.
        reset = 1'b1; mask_in = 4'hF; ld_mask = 1'b1; mode_in = 4'hF; ld_mode = 1'b1;
        tick();
        ld_mask = 1'b0; ld_mode = 1'b0;

        // Ack while idle must be ignored.
        int_ack = 1'b1; tick(); int_ack = 1'b0;
        chk("idle_ack_insvc", 32'(in_service), 32'd0);

        // Single edge pulse on channel 2.
        ints = 4'b0100; push_exp(2'd2, 8'hF8, 2);
        wait_req("c2", 4'b0000);
        chk("c2_pend", 32'(pend_out), 32'b0100);
        do_ack(4'b0000);
        chk("c2_ack_pending", 32'(int_pending), 32'd0);
        chk("c2_ack_insvc", 32'(in_service), 32'b0100);
        chk("c2_ack_pend", 32'(pend_out), 32'd0);
        do_eoi();
        chk("c2_eoi_insvc", 32'(in_service), 32'd0);

        // Simultaneous edges on 1 and 3: 1 wins, 3 waits for EOI of 1.
        ints = 4'b1010; push_exp(2'd1, 8'hF4, 2);
        wait_req("c13", 4'b0000);
        do_ack(4'b0000);
        chk("c13_insvc", 32'(in_service), 32'b0010);
        tick(); tick(); tick();
        chk("c13_blocked", 32'(int_pending), 32'd0);
        chk("c13_pend3", 32'(pend_out), 32'b1000);
        eoi = 1'b1; push_exp(2'd3, 8'hFC, 2);
        wait_req("c3", 4'b0000);
        do_ack(4'b0000);
        chk("c3_insvc", 32'(in_service), 32'b1000);
        do_eoi();

        // Nesting: 0 preempts 2; 3 waits for both EOIs.
        ints = 4'b0100; push_exp(2'd2, 8'hF8, 2);
        wait_req("n2", 4'b0000);
        do_ack(4'b0000);
        ints = 4'b0001; push_exp(2'd0, 8'hF0, 2);
        wait_req("n0", 4'b0000);
        do_ack(4'b0000);
        chk("n_insvc", 32'(in_service), 32'b0101);
        ints = 4'b1000; tick(); ints = 4'b0000; tick(); tick();
        chk("n3_blocked_a", 32'(int_pending), 32'd0);
        do_eoi();
        chk("n_eoi1_insvc", 32'(in_service), 32'b0100);
        tick(); tick();
        chk("n3_blocked_b", 32'(int_pending), 32'd0);
        eoi = 1'b1; push_exp(2'd3, 8'hFC, 2);
        wait_req("n3", 4'b0000);
        do_ack(4'b0000);
        do_eoi();
        chk("n_final_insvc", 32'(in_service), 32'd0);

        // Level mode on channel 0 only.
        mask_in = 4'b0001; ld_mask = 1'b1; mode_in = 4'b0000; ld_mode = 1'b1;
        tick();
        ld_mask = 1'b0; ld_mode = 1'b0;
        ints = 4'b0001; push_exp(2'd0, 8'hF0, 2);
        wait_req("lv", 4'b0001);
        ints = 4'b0000; tick();
        chk("lv_frozen_pending", 32'(int_pending), 32'd1);
        chk("lv_frozen_id", 32'(int_id), 32'd0);
        chk("lv_pend_drop", 32'(pend_out), 32'd0);

        // Withdraw via int_disable, then re-request one cycle after release.
        ints = 4'b0001; tick();
        int_disable = 1'b1; tick();
        chk("dis_pending", 32'(int_pending), 32'd0);
        chk("dis_pend", 32'(pend_out), 32'b0001);
        int_disable = 1'b0; push_exp(2'd0, 8'hF0, 1);
        wait_req("dis", 4'b0001);
        do_ack(4'b0000);
        chk("dis_insvc", 32'(in_service), 32'b0001);

        // Build in_service=1000 then reset in the middle of a request.
        mask_in = 4'hF; ld_mask = 1'b1; mode_in = 4'hF; ld_mode = 1'b1; eoi = 1'b1;
        tick();
        ld_mask = 1'b0; ld_mode = 1'b0; eoi = 1'b0;
        ints = 4'b1000; push_exp(2'd3, 8'hFC, 2);
        wait_req("r3", 4'b0000);
        do_ack(4'b0000);
        ints = 4'b0100; push_exp(2'd2, 8'hF8, 2);
        wait_req("r2", 4'b0000);
        chk("r_insvc", 32'(in_service), 32'b1000);
        reset = 1'b0; tick();
        chk("mid_rst_pending", 32'(int_pending), 32'd0);
        chk("mid_rst_id", 32'(int_id), 32'd0);
        chk("mid_rst_addr", 32'(isr_addr), 32'hF0);
        chk("mid_rst_pend", 32'(pend_out), 32'd0);
        chk("mid_rst_insvc", 32'(in_service), 32'd0);
        reset = 1'b1; ints = 4'b0010;
        tick(); tick(); tick();
        chk("post_rst_masked", 32'(int_pending), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
